// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared state type and default timing for the FIR sequencer
package eq_pkg;

    // Default number of FIR taps, i.e. cycles of sequencing per sample.
    localparam int SEQ_LEN_DEF   = 1021;
    // Default sample-queue read latency before the run starts.
    localparam int START_DLY_DEF = 1;
    // Default ROM plus MAC pipeline depth after the run ends.
    localparam int FLUSH_DEF     = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_LATCH = 3'd4
    } seq_state_t;

    // A sample arriving in one of these states cannot be taken and is lost.
    function automatic logic state_is_busy(input seq_state_t s);
        return (s == ST_WAIT) || (s == ST_RUN) || (s == ST_FLUSH);
    endfunction

endpackage

// File: rtl/fir_sequencer.sv
// rtl/fir_sequencer.sv - per-sample run/flush/latch sequencing of the FIR band
module fir_sequencer
    import eq_pkg::*;
#(
    parameter int SEQ_LEN   = SEQ_LEN_DEF,
    parameter int START_DLY = START_DLY_DEF,
    parameter int FLUSH     = FLUSH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_rise,
    input  logic               queue_full,
    input  logic               clr_ovr,
    input  logic signed [15:0] filt_L_in,
    input  logic signed [15:0] filt_R_in,
    output logic               sequencing,
    output logic signed [15:0] lft_out,
    output logic signed [15:0] rht_out,
    output logic               out_valid,
    output logic               overrun
);

    // One counter serves every timed phase; it holds (remaining cycles - 1).
    localparam int CNT_W = $clog2(SEQ_LEN + 1);

    localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(START_DLY - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    seq_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_cnt_done;

    // A sample only counts when the queue is primed.
    assign w_accept   = valid_rise && queue_full;
    assign w_cnt_done = (r_cnt == '0);

    // Phase sequencer: state, phase counter and all registered outputs except overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            sequencing <= 1'b0;
            out_valid  <= 1'b0;
            lft_out    <= '0;
            rht_out    <= '0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (START_DLY == 0) begin
                            r_state    <= ST_RUN;
                            r_cnt      <= RUN_LOAD;
                            sequencing <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_cnt_done) begin
                        r_state    <= ST_RUN;
                        r_cnt      <= RUN_LOAD;
                        sequencing <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (w_cnt_done) begin
                        r_state    <= ST_FLUSH;
                        r_cnt      <= FLUSH_LOAD;
                        sequencing <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_FLUSH: begin
                    if (w_cnt_done) begin
                        r_state <= ST_LATCH;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_LATCH: begin
                    // Pipeline has drained; capture results and let a waiting
                    // sample start straight away instead of dropping it.
                    lft_out   <= filt_L_in;
                    rht_out   <= filt_R_in;
                    out_valid <= 1'b1;
                    if (w_accept) begin
                        if (START_DLY == 0) begin
                            r_state    <= ST_RUN;
                            r_cnt      <= RUN_LOAD;
                            sequencing <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= WAIT_LOAD;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_cnt      <= '0;
                    sequencing <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun: a lost sample sets it, and setting beats clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (w_accept && state_is_busy(r_state)) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_sequencer.sv
// tb/tb_fir_sequencer.sv - directed-vector bench for fir_sequencer
module tb_fir_sequencer;

    logic               clk;
    logic               rst_n;
    logic               valid_rise;
    logic               queue_full;
    logic               clr_ovr;
    logic signed [15:0] filt_L_in;
    logic signed [15:0] filt_R_in;
    logic               sequencing;
    logic signed [15:0] lft_out;
    logic signed [15:0] rht_out;
    logic               out_valid;
    logic               overrun;

    logic               d_valid;
    logic               d_qf;
    logic               d_clr;
    logic signed [15:0] d_filt_l;
    logic signed [15:0] d_filt_r;
    logic               d_seq;
    logic signed [15:0] d_lft;
    logic signed [15:0] d_rht;
    logic               d_oval;
    logic               d_ovr;

    int n_vec;
    int n_miss;

    logic [31:0] seq_vec;
    logic [31:0] oval_vec;
    logic [31:0] ovr_vec;
    logic [15:0] lft_log [0:31];
    logic [15:0] rht_log [0:31];

    fir_sequencer #(
        .SEQ_LEN   (8),
        .START_DLY (1),
        .FLUSH     (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_rise (valid_rise),
        .queue_full (queue_full),
        .clr_ovr    (clr_ovr),
        .filt_L_in  (filt_L_in),
        .filt_R_in  (filt_R_in),
        .sequencing (sequencing),
        .lft_out    (lft_out),
        .rht_out    (rht_out),
        .out_valid  (out_valid),
        .overrun    (overrun)
    );

    fir_sequencer dut_def (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_rise (d_valid),
        .queue_full (d_qf),
        .clr_ovr    (d_clr),
        .filt_L_in  (d_filt_l),
        .filt_R_in  (d_filt_r),
        .sequencing (d_seq),
        .lft_out    (d_lft),
        .rht_out    (d_rht),
        .out_valid  (d_oval),
        .overrun    (d_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        valid_rise = 1'b0;
        queue_full = 1'b0;
        clr_ovr    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 starts 1ns after a posedge; valid_rise is driven in cycle 0 and
    // again in cycle v2 (if >= 0). Outputs are logged at each negedge.
    task automatic run_scenario(input int n_cyc, input int v2, input int clr_c,
                                input int qf_until, input int rst_c, input int rst_len);
        seq_vec  = '0;
        oval_vec = '0;
        ovr_vec  = '0;
        for (int c = 0; c < n_cyc; c++) begin
            valid_rise = (c == 0) || (c == v2);
            queue_full = (c < qf_until);
            clr_ovr    = (c == clr_c);
            filt_L_in  = (c <= 12) ? 16'sh1234 : 16'sh0BAD;
            filt_R_in  = (c <= 12) ? 16'shFEDC : 16'sh8001;
            if (c == rst_c) rst_n = 1'b0;
            if (c == rst_c + rst_len) rst_n = 1'b1;
            @(negedge clk);
            seq_vec[c]  = sequencing;
            oval_vec[c] = out_valid;
            ovr_vec[c]  = overrun;
            lft_log[c]  = lft_out;
            rht_log[c]  = rht_out;
            @(posedge clk);
            #1;
        end
        valid_rise = 1'b0;
        clr_ovr    = 1'b0;
    endtask

    initial begin
        int d_cnt;
        int d_first;
        n_vec    = 0;
        n_miss   = 0;
        rst_n    = 1'b0;
        valid_rise = 1'b0;
        queue_full = 1'b0;
        clr_ovr  = 1'b0;
        filt_L_in = 16'sh0;
        filt_R_in = 16'sh0;
        d_valid  = 1'b0;
        d_qf     = 1'b0;
        d_clr    = 1'b0;
        d_filt_l = 16'sh0;
        d_filt_r = 16'sh0;

        // Reset state, observed while rst_n is still low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_eq("rst_sequencing", {31'b0, sequencing}, 32'h0);
        expect_eq("rst_out_valid",  {31'b0, out_valid},  32'h0);
        expect_eq("rst_overrun",    {31'b0, overrun},    32'h0);
        expect_eq("rst_lft_out",    {16'b0, lft_out},    32'h0);
        expect_eq("rst_rht_out",    {16'b0, rht_out},    32'h0);

        // Single sample: run 2..9, out_valid at 13.
        do_reset();
        run_scenario(20, -1, -1, 32, -1, 0);
        expect_eq("single_seq",     seq_vec,  32'h0000_03FC);
        expect_eq("single_oval",    oval_vec, 32'h0000_2000);
        expect_eq("single_lft",     {16'b0, lft_log[13]}, 32'h1234);
        expect_eq("single_rht",     {16'b0, rht_log[13]}, 32'hFEDC);
        expect_eq("single_ovr",     ovr_vec,  32'h0);

        // Back-to-back: second sample in LATCH cycle 12, run 14..21, out_valid 25.
        do_reset();
        run_scenario(30, 12, -1, 32, -1, 0);
        expect_eq("b2b_seq",        seq_vec,  32'h003F_C3FC);
        expect_eq("b2b_oval",       oval_vec, 32'h0200_2000);
        expect_eq("b2b_lft1",       {16'b0, lft_log[13]}, 32'h1234);
        expect_eq("b2b_lft2",       {16'b0, lft_log[25]}, 32'h0BAD);
        expect_eq("b2b_rht2",       {16'b0, rht_log[25]}, 32'h8001);
        expect_eq("b2b_ovr",        ovr_vec,  32'h0);

        // Overrun: second sample at 5 sets the flag from 6; clear at 20.
        do_reset();
        run_scenario(24, 5, 20, 32, -1, 0);
        expect_eq("ovr_flag",       ovr_vec,  32'h001F_FFC0);
        expect_eq("ovr_oval",       oval_vec, 32'h0000_2000);
        expect_eq("ovr_seq",        seq_vec,  32'h0000_03FC);

        // Not primed: nothing happens.
        do_reset();
        run_scenario(20, 5, -1, 0, -1, 0);
        expect_eq("noprime_seq",    seq_vec,  32'h0);
        expect_eq("noprime_oval",   oval_vec, 32'h0);
        expect_eq("noprime_ovr",    ovr_vec,  32'h0);

        // queue_full drops at 3: sample completes; unprimed pulse at 5 is ignored.
        do_reset();
        run_scenario(20, 5, -1, 3, -1, 0);
        expect_eq("qfdrop_seq",     seq_vec,  32'h0000_03FC);
        expect_eq("qfdrop_oval",    oval_vec, 32'h0000_2000);
        expect_eq("qfdrop_ovr",     ovr_vec,  32'h0);

        // Reset mid-run at cycle 6: sequencing low in that same cycle, no output.
        do_reset();
        run_scenario(20, -1, -1, 1, 6, 3);
        expect_eq("midrst_seq",     seq_vec,  32'h0000_003C);
        expect_eq("midrst_oval",    oval_vec, 32'h0);
        expect_eq("midrst_lft",     {16'b0, lft_log[19]}, 32'h0);
        expect_eq("midrst_ovr",     ovr_vec,  32'h0);

        // Default parameters: 1021 run cycles, out_valid 1026 cycles after valid_rise.
        do_reset();
        d_cnt   = 0;
        d_first = -1;
        d_qf    = 1'b1;
        for (int c = 0; c < 1100; c++) begin
            d_valid = (c == 0);
            @(negedge clk);
            if (d_seq) d_cnt++;
            if (d_oval && d_first < 0) d_first = c;
            @(posedge clk);
            #1;
        end
        d_valid = 1'b0;
        expect_eq("default_run_len",  d_cnt,   32'd1021);
        expect_eq("default_latency",  d_first, 32'd1026);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fir_sequencer.md
FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 Parameter SEQ_LEN, default 1021: number of consecutive cycles sequencing is held high per sample (one cycle per FIR tap).
REQ-002 Parameter START_DLY, default 1: cycles between accepting a sample and raising sequencing (sample-queue read latency); legal range 0..7.
REQ-003 Parameter FLUSH, default 2: cycles after sequencing falls before filter outputs are stable (ROM plus MAC pipeline); legal range 1..7.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-005 clk  input  1  system clock; all logic rising-edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 valid_rise  input  1  single-cycle pulse: a new left/right sample pair is ready in the sample queue.
REQ-008 queue_full  input  1  sample queue primed; samples are not processed while low.
REQ-009 clr_ovr  input  1  synchronous clear of the overrun flag.
REQ-010 filt_L_in, filt_R_in  input  16 each  signed filtered outputs from the FIR band.
REQ-011 sequencing  output  1  run-enable to the FIR band; high means accumulate and advance the coefficient address.
REQ-012 lft_out, rht_out  output  16 each  signed registered filter results.
REQ-013 out_valid  output  1  single-cycle pulse: lft_out/rht_out were updated this cycle.
REQ-014 overrun  output  1  sticky flag: a sample arrived while a computation was in progress.

Function
REQ-015 FSM states: IDLE, WAIT, RUN, FLUSH, LATCH; state encoding registered; sequencing is a registered output equal to (state==RUN).
REQ-016 IDLE: valid_rise && queue_full -> WAIT, or -> RUN if START_DLY==0; otherwise stay in IDLE.
REQ-017 WAIT lasts exactly START_DLY cycles, then -> RUN.
REQ-018 RUN lasts exactly SEQ_LEN cycles (sequencing high for exactly SEQ_LEN consecutive cycles), then -> FLUSH.
REQ-019 FLUSH lasts exactly FLUSH cycles with sequencing low, then -> LATCH.
REQ-020 LATCH lasts one cycle: lft_out<=filt_L_in, rht_out<=filt_R_in; out_valid high in the following cycle, aligned with the new output values; then -> IDLE.
REQ-021 A valid_rise && queue_full in the LATCH cycle is accepted: the next state is WAIT (or RUN if START_DLY==0) instead of IDLE; the sample is not dropped and overrun is not set.
REQ-022 Latency from the accepted valid_rise edge to the out_valid edge is START_DLY+SEQ_LEN+FLUSH+2 cycles.
REQ-023 A valid_rise in WAIT, RUN or FLUSH is dropped: the FSM is unaffected and overrun is set to 1.
REQ-024 A valid_rise while queue_full is low is ignored in every state and never sets overrun.
REQ-025 A single phase counter, sized $clog2(SEQ_LEN+1) bits, is loaded on each state entry and counts down; no wrap-around is permitted.
REQ-026 Overrun is cleared by clr_ovr; when clr_ovr and a set condition occur in the same cycle, the set wins.
REQ-027 sequencing never stays high across samples: there are at least FLUSH+1 low cycles between consecutive RUN phases, so the FIR band always re-initialises.
REQ-028 queue_full falling mid-computation does not abort the current sample.

Reset
REQ-029 While rst_n is low: state=IDLE, counter=0, sequencing=0, out_valid=0, overrun=0, lft_out=0, rht_out=0.
REQ-030 Reset asserted mid-RUN drops sequencing low asynchronously, and the partial sample is discarded with no out_valid.
REQ-031 After rst_n rises, the first accepted valid_rise is the earliest one with queue_full high.

Structure
REQ-032 The state enum and the default values of SEQ_LEN, START_DLY and FLUSH belong in the shared package eq_pkg.
REQ-033 The block is a single module with no sub-modules; it instantiates no ROM and no FIR band.

Verification (SEQ_LEN=8, START_DLY=1, FLUSH=2)
REQ-034 Single sample: valid_rise at cycle 0 with queue_full=1 -> sequencing high for cycles 2..9; filt_L_in=0x1234 and filt_R_in=0xFEDC are captured; out_valid pulses at cycle 13 with lft_out=0x1234 and rht_out=0xFEDC.
REQ-035 Back-to-back: a second valid_rise in the LATCH cycle (12) -> second RUN spans cycles 14..21; overrun stays 0.
REQ-036 Overrun: a second valid_rise at cycle 5 -> overrun=1 and only one out_valid; clr_ovr at cycle 20 -> overrun=0.
REQ-037 Not primed: valid_rise with queue_full=0 -> sequencing stays 0, no out_valid, overrun stays 0.
REQ-038 Reset mid-RUN: rst_n low at cycle 6 -> sequencing is 0 within the same cycle, all outputs return to 0, and no out_valid is produced.
REQ-039 Default parameters: one sample -> sequencing high for exactly 1021 cycles and out_valid 1026 cycles after valid_rise.
